// File: rtl/fp_pkg.sv
// Shared class codes and canonical-NaN helper for the floating-point special-case pipeline.
package fp_pkg;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    SUBNORM = 3'd1,
    NORMAL  = 3'd2,
    PINF    = 3'd3,
    NINF    = 3'd4,
    NAN     = 3'd5
  } fp_class_e;

  // Quiet-NaN stored mantissa: only the MSB of an mant_w-bit field set.
  function automatic logic [63:0] qnan_mant(input int mant_w);
    qnan_mant = 64'd1 << (mant_w - 1);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fp_lzc #(
  parameter int W = 10
) (
  input  logic [W-1:0]             data_i,
  output logic [$clog2(W+1)-1:0]   lz_o
);

  localparam int CW = $clog2(W + 1);

  logic found;

  always_comb begin
    lz_o  = CW'(W);
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        lz_o  = CW'(W - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_special_pipe.sv
// Two-stage IEEE-754 special-case classifier with subnormal pre-normalisation.
// Optional per-class output counters are built when FP_SPECIAL_STATS_EN is defined.
module fp_special_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
`ifdef FP_SPECIAL_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                mode_sqrt,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_W-1:0]    in_exp,
  input  logic [MANT_W-1:0]   in_mant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          out_class,
  output logic                is_nan,
  output logic                is_pinf,
  output logic                is_ninf,
  output logic                is_zero,
  output logic                is_normal,
  output logic                is_subnormal,
  output logic                sign_out,
  output logic [EXP_W-1:0]    exp_out,
  output logic [MANT_W-1:0]   mant_out,
  output logic [EXP_W+1:0]    norm_exp,
  output logic [MANT_W-1:0]   norm_mant
`ifdef FP_SPECIAL_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [CNT_W-1:0]    stats_nan,
  output logic [CNT_W-1:0]    stats_inf,
  output logic [CNT_W-1:0]    stats_sub
`endif
);

  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int LZW  = $clog2(MANT_W + 1);
  localparam int NW   = EXP_W + 2;
  localparam logic [MANT_W-1:0] QNAN_MANT = MANT_W'(qnan_mant(MANT_W));

  logic adv;
  logic exp_ones, exp_zero, mant_zero;
  fp_class_e cls_d;
  logic [LZW-1:0] lz_d;

  logic              s1_valid_q;
  fp_class_e         s1_class_q;
  logic              s1_sign_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic [MANT_W-1:0] s1_mant_q;
  logic [LZW-1:0]    s1_lz_q;

  logic              sign_d;
  logic [EXP_W-1:0]  exp_d;
  logic [MANT_W-1:0] mant_d;
  logic [NW-1:0]     nexp_d;
  logic [MANT_W-1:0] nmant_d;
  logic [5:0]        flags_d;

  logic              out_valid_q;
  logic [2:0]        out_class_q;
  logic [5:0]        flags_q;
  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mant_q;
  logic [NW-1:0]     nexp_q;
  logic [MANT_W-1:0] nmant_q;

  // Whole pipe stalls together; bubbles are carried, not squeezed out.
  assign adv      = enable && (!out_valid_q || out_ready);
  assign in_ready = adv && rst_n;

  assign exp_ones  = &in_exp;
  assign exp_zero  = ~|in_exp;
  assign mant_zero = ~|in_mant;

  fp_lzc #(.W(MANT_W)) u_lzc (
    .data_i (in_mant),
    .lz_o   (lz_d)
  );

  always_comb begin
    cls_d = ZERO;
    if (exp_ones && !mant_zero)
      cls_d = NAN;
    else if (mode_sqrt && in_sign && !(exp_zero && mant_zero) && !exp_ones)
      cls_d = NAN;
    else if (exp_ones)
      cls_d = in_sign ? NINF : PINF;
    else if (!exp_zero)
      cls_d = NORMAL;
    else if (!mant_zero)
      cls_d = SUBNORM;
  end

  always_comb begin
    sign_d  = s1_sign_q;
    exp_d   = s1_exp_q;
    mant_d  = s1_mant_q;
    nexp_d  = '0;
    nmant_d = '0;
    flags_d = 6'b000001 << s1_class_q;
    case (s1_class_q)
      NAN: begin
        sign_d = 1'b1;
        exp_d  = '1;
        mant_d = QNAN_MANT;
      end
      NORMAL: begin
        nexp_d  = NW'({2'b00, s1_exp_q}) - NW'(BIAS);
        nmant_d = s1_mant_q;
      end
      // Subnormal value = 0.mant * 2^(1-BIAS); shift the leading 1 out as the implicit bit.
      SUBNORM: begin
        nexp_d  = NW'(0) - NW'(BIAS) - NW'(s1_lz_q);
        nmant_d = s1_mant_q << (s1_lz_q + LZW'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_class_q  <= ZERO;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_mant_q   <= '0;
      s1_lz_q     <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      flags_q     <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      nexp_q      <= '0;
      nmant_q     <= '0;
    end else if (!enable) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_class_q  <= cls_d;
      s1_sign_q   <= in_sign;
      s1_exp_q    <= in_exp;
      s1_mant_q   <= in_mant;
      s1_lz_q     <= lz_d;
      out_valid_q <= s1_valid_q;
      out_class_q <= s1_class_q;
      flags_q     <= flags_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      nexp_q      <= nexp_d;
      nmant_q     <= nmant_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_class    = out_class_q;
  assign is_zero      = flags_q[0];
  assign is_subnormal = flags_q[1];
  assign is_normal    = flags_q[2];
  assign is_pinf      = flags_q[3];
  assign is_ninf      = flags_q[4];
  assign is_nan       = flags_q[5];
  assign sign_out     = sign_q;
  assign exp_out      = exp_q;
  assign mant_out     = mant_q;
  assign norm_exp     = nexp_q;
  assign norm_mant    = nmant_q;

`ifdef FP_SPECIAL_STATS_EN
  logic [CNT_W-1:0] nan_cnt_q, inf_cnt_q, sub_cnt_q;
  logic             out_hs;

  assign out_hs = out_valid_q && out_ready;

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_cnt_q <= '0;
      inf_cnt_q <= '0;
      sub_cnt_q <= '0;
    end else if (stats_clr) begin
      nan_cnt_q <= '0;
      inf_cnt_q <= '0;
      sub_cnt_q <= '0;
    end else if (out_hs) begin
      if (flags_q[5] && (nan_cnt_q != '1))
        nan_cnt_q <= nan_cnt_q + CNT_W'(1);
      if ((flags_q[3] || flags_q[4]) && (inf_cnt_q != '1))
        inf_cnt_q <= inf_cnt_q + CNT_W'(1);
      if (flags_q[1] && (sub_cnt_q != '1))
        sub_cnt_q <= sub_cnt_q + CNT_W'(1);
    end
  end

  assign stats_nan = nan_cnt_q;
  assign stats_inf = inf_cnt_q;
  assign stats_sub = sub_cnt_q;
`endif

endmodule

// File: tb/tb_fp_special_pipe.sv
// Scoreboard bench for fp_special_pipe (half precision); stats checks compile in with FP_SPECIAL_STATS_EN.
module tb_fp_special_pipe;

  typedef struct packed {
    logic [2:0]  cls;
    logic [15:0] w;
    logic [6:0]  ne;
    logic [9:0]  nm;
  } exp_t;

  typedef struct packed {
    logic [15:0] h;
    logic        ms;
    exp_t        e;
  } vec_t;

  logic clk, rst_n, enable, mode_sqrt, in_valid, in_ready, in_sign;
  logic [4:0] in_exp;
  logic [9:0] in_mant;
  logic out_valid, out_ready;
  logic [2:0] out_class;
  logic is_nan, is_pinf, is_ninf, is_zero, is_normal, is_subnormal;
  logic sign_out;
  logic [4:0] exp_out;
  logic [9:0] mant_out;
  logic [6:0] norm_exp;
  logic [9:0] norm_mant;
`ifdef FP_SPECIAL_STATS_EN
  logic stats_clr;
  logic [1:0] stats_nan, stats_inf, stats_sub;
`endif

  int checks = 0;
  int errors = 0;
  int txn = 0;
  exp_t exp_q[$];
  vec_t vecs[15];

  fp_special_pipe #(
    .EXP_W  (5),
    .MANT_W (10)
`ifdef FP_SPECIAL_STATS_EN
    ,
    .CNT_W  (2)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .mode_sqrt    (mode_sqrt),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_class    (out_class),
    .is_nan       (is_nan),
    .is_pinf      (is_pinf),
    .is_ninf      (is_ninf),
    .is_zero      (is_zero),
    .is_normal    (is_normal),
    .is_subnormal (is_subnormal),
    .sign_out     (sign_out),
    .exp_out      (exp_out),
    .mant_out     (mant_out),
    .norm_exp     (norm_exp),
    .norm_mant    (norm_mant)
`ifdef FP_SPECIAL_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .stats_nan    (stats_nan),
    .stats_inf    (stats_inf),
    .stats_sub    (stats_sub)
`endif
  );

  always #5 clk = ~clk;

  logic [5:0]  flags_now;
  logic [41:0] outs_now;
  assign flags_now = {is_nan, is_ninf, is_pinf, is_normal, is_subnormal, is_zero};
  assign outs_now  = {out_class, flags_now, sign_out, exp_out, mant_out, norm_exp, norm_mant};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] h, input logic ms, input logic [2:0] c,
                              input logic [15:0] w, input int ne, input logic [9:0] nm);
    vec_t v;
    v.h = h; v.ms = ms; v.e.cls = c; v.e.w = w; v.e.ne = 7'(ne); v.e.nm = nm;
    return v;
  endfunction

  // Output monitor: pops the scoreboard on each output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", outs_now);
      end else begin
        e = exp_q.pop_front();
        chk("class", 64'(out_class), 64'(e.cls));
        chk("word", 64'({sign_out, exp_out, mant_out}), 64'(e.w));
        chk("norm", 64'({norm_exp, norm_mant}), 64'({e.ne, e.nm}));
        chk("flags", 64'(flags_now), 64'(6'b000001 << e.cls));
        $display("txn %0d class=%0d word=%h norm_exp=%0d norm_mant=%h", txn, out_class,
                 {sign_out, exp_out, mant_out}, $signed(norm_exp), norm_mant);
        txn++;
      end
    end
  end

  // Outputs must hold while the consumer back-pressures.
  logic [41:0] snap;
  logic        stalled_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && out_valid && !out_ready) begin
      if (stalled_prev) chk("stall_hold", 64'(outs_now), 64'(snap));
      snap = outs_now;
      stalled_prev = 1'b1;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    {in_sign, in_exp, in_mant} = v.h;
    mode_sqrt = v.ms;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) exp_q.push_back(v.e);
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept operand=%h", v.h);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; mode_sqrt = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
`ifdef FP_SPECIAL_STATS_EN
    stats_clr = 1'b0;
`endif
    vecs[0]  = mk(16'h3C00, 1'b1, 3'd2, 16'h3C00,   0, 10'h000);
    vecs[1]  = mk(16'hC000, 1'b1, 3'd5, 16'hFE00,   0, 10'h000);
    vecs[2]  = mk(16'hC000, 1'b0, 3'd2, 16'hC000,   1, 10'h000);
    vecs[3]  = mk(16'h0001, 1'b1, 3'd1, 16'h0001, -24, 10'h000);
    vecs[4]  = mk(16'h0200, 1'b1, 3'd1, 16'h0200, -15, 10'h000);
    vecs[5]  = mk(16'h7C00, 1'b1, 3'd3, 16'h7C00,   0, 10'h000);
    vecs[6]  = mk(16'hFC00, 1'b1, 3'd4, 16'hFC00,   0, 10'h000);
    vecs[7]  = mk(16'h8000, 1'b1, 3'd0, 16'h8000,   0, 10'h000);
    vecs[8]  = mk(16'h7C01, 1'b0, 3'd5, 16'hFE00,   0, 10'h000);
    vecs[9]  = mk(16'h3555, 1'b0, 3'd2, 16'h3555,  -2, 10'h155);
    vecs[10] = mk(16'h0055, 1'b1, 3'd1, 16'h0055, -18, 10'h150);
    vecs[11] = mk(16'h8055, 1'b0, 3'd1, 16'h8055, -18, 10'h150);
    vecs[12] = mk(16'h8055, 1'b1, 3'd5, 16'hFE00,   0, 10'h000);
    vecs[13] = mk(16'h7BFF, 1'b1, 3'd2, 16'h7BFF,  15, 10'h3FF);
    vecs[14] = mk(16'hFFFF, 1'b0, 3'd5, 16'hFE00,   0, 10'h000);

    #3;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'(outs_now), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    send(vecs[0]);
    @(negedge clk); chk("latency_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk); chk("latency_cycle2", 64'(out_valid), 64'd1);
    wait_drain();

    for (int i = 1; i < 15; i++) begin
      send(vecs[i]);
      wait_drain();
    end

    for (int i = 0; i < 15; i++) send(vecs[i]);
    wait_drain();

    fork
      begin
        for (int i = 0; i < 8; i++) send(vecs[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    out_ready = 1'b0;
    send(vecs[9]);
    send(vecs[10]);
    enable = 1'b0;
    @(negedge clk); chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); chk("flush_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    enable = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); chk("restart_empty", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(vecs[3]);
    wait_drain();

    send(vecs[4]);
    send(vecs[5]);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'(outs_now), 64'd0);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    send(vecs[13]);
    wait_drain();

`ifdef FP_SPECIAL_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    chk("stats_clr_nan", 64'(stats_nan), 64'd0);
    send(vecs[1]); send(vecs[8]); send(vecs[12]); send(vecs[14]); send(vecs[1]);
    wait_drain();
    @(posedge clk); #1;
    chk("stats_nan_sat", 64'(stats_nan), 64'd3);
    chk("stats_inf", 64'(stats_inf), 64'd0);
    chk("stats_sub", 64'(stats_sub), 64'd0);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    chk("stats_clr_after", 64'(stats_nan), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
